// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART constants used by rx_core, tx_core and the receive/transmit FIFOs.
package uart_rx_fifo_pkg;
    localparam int UART_DATA_W     = 8;
    localparam int UART_FIFO_DEPTH = 16;
    localparam int UART_FIFO_AW    = $clog2(UART_FIFO_DEPTH);
endpackage

// File: rtl/uart_sync_fifo.sv
// Generic single-clock show-ahead FIFO with registered head, valid and occupancy.
module uart_sync_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [ADDR_W:0]   count,
    output logic              full
);

    localparam logic [ADDR_W:0] FULL_C = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_r, rd_ptr_r, wr_nxt_s, rd_nxt_s;
    logic [ADDR_W:0]   count_r, cnt_nxt_s;
    logic [DATA_W-1:0] rd_data_r, head_s;
    logic              rd_valid_r, full_s, push_s, pop_s;

    // Next-state pointers, occupancy and head entry; clr beats push and pop.
    always_comb begin
        full_s    = (count_r == FULL_C);
        pop_s     = rd_en & rd_valid_r;
        push_s    = wr_en & (~full_s | pop_s) & ~clr;
        wr_nxt_s  = wr_ptr_r;
        rd_nxt_s  = rd_ptr_r;
        cnt_nxt_s = count_r;
        head_s    = '0;
        if (clr) begin
            wr_nxt_s  = '0;
            rd_nxt_s  = '0;
            cnt_nxt_s = '0;
        end else begin
            wr_nxt_s = push_s ? wr_ptr_r + ADDR_W'(1) : wr_ptr_r;
            rd_nxt_s = pop_s  ? rd_ptr_r + ADDR_W'(1) : rd_ptr_r;
            case ({push_s, pop_s})
                2'b10:   cnt_nxt_s = count_r + (ADDR_W+1)'(1);
                2'b01:   cnt_nxt_s = count_r - (ADDR_W+1)'(1);
                default: cnt_nxt_s = count_r;
            endcase
        end
        // The entry landing at the new head this cycle is not in mem_r yet.
        if (cnt_nxt_s == '0) begin
            head_s = '0;
        end else if (push_s && (wr_ptr_r == rd_nxt_s)) begin
            head_s = wr_data;
        end else begin
            head_s = mem_r[rd_nxt_s];
        end
    end

    // Storage write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointer, occupancy and head registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            rd_data_r  <= '0;
            rd_valid_r <= 1'b0;
        end else begin
            wr_ptr_r   <= wr_nxt_s;
            rd_ptr_r   <= rd_nxt_s;
            count_r    <= cnt_nxt_s;
            rd_data_r  <= head_s;
            rd_valid_r <= (cnt_nxt_s != '0);
        end
    end

    assign rd_data  = rd_data_r;
    assign rd_valid = rd_valid_r;
    assign count    = count_r;
    assign full     = full_s;

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive byte buffer behind rx_core: rx_done edge capture, FIFO, sticky overflow.
// Optional threshold interrupt rx_irq when UART_RX_IRQ_EN is defined.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int DEPTH  = UART_FIFO_DEPTH,
    parameter int ADDR_W = UART_FIFO_AW,
    parameter int DATA_W = UART_DATA_W
`ifdef UART_RX_IRQ_EN
    ,
    parameter int IRQ_LEVEL = DEPTH / 2
`endif
) (
    input  logic              rx_clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_done,
    input  logic              rd_pop,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              flush,
    input  logic              ovf_clr,
    output logic              overflow,
`ifdef UART_RX_IRQ_EN
    output logic              rx_irq,
`endif
    output logic [ADDR_W:0]   count
);

    logic rx_done_d_r, overflow_r;
    logic push_req_s, pop_v_s, full_s, ovf_set_s, ovf_nxt_s;

    uart_sync_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk      (rx_clk),
        .rst_n    (reset_n),
        .clr      (flush),
        .wr_en    (push_req_s),
        .wr_data  (rx_data),
        .rd_en    (rd_pop),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .count    (count),
        .full     (full_s)
    );

    // Edge detect and overflow decision; a flushed byte is never an overflow.
    always_comb begin
        push_req_s = rx_done & ~rx_done_d_r;
        pop_v_s    = rd_pop & rd_valid;
        ovf_set_s  = push_req_s & full_s & ~pop_v_s & ~flush;
        if (ovf_set_s) begin
            ovf_nxt_s = 1'b1;
        end else if (ovf_clr) begin
            ovf_nxt_s = 1'b0;
        end else begin
            ovf_nxt_s = overflow_r;
        end
    end

    // rx_done_d resets high so a strobe already asserted at release is ignored.
    always_ff @(posedge rx_clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_done_d_r <= 1'b1;
            overflow_r  <= 1'b0;
        end else begin
            rx_done_d_r <= rx_done;
            overflow_r  <= ovf_nxt_s;
        end
    end

    assign overflow = overflow_r;

`ifdef UART_RX_IRQ_EN
    localparam logic [ADDR_W:0] IRQ_LVL_C = (ADDR_W+1)'(IRQ_LEVEL);

    logic [ADDR_W:0] cnt_nxt_s;
    logic            accept_s, rx_irq_r;

    // Occupancy the FIFO will hold after this edge, so rx_irq lines up with rd_valid.
    always_comb begin
        accept_s = push_req_s & (~full_s | pop_v_s);
        if (flush) begin
            cnt_nxt_s = '0;
        end else begin
            case ({accept_s, pop_v_s})
                2'b10:   cnt_nxt_s = count + (ADDR_W+1)'(1);
                2'b01:   cnt_nxt_s = count - (ADDR_W+1)'(1);
                default: cnt_nxt_s = count;
            endcase
        end
    end

    // Threshold or overflow interrupt.
    always_ff @(posedge rx_clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_irq_r <= 1'b0;
        end else begin
            rx_irq_r <= (cnt_nxt_s >= IRQ_LVL_C) | ovf_nxt_s;
        end
    end

    assign rx_irq = rx_irq_r;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed plus random bench for uart_rx_fifo against a queue-based reference model.
module tb_uart_rx_fifo;
    localparam int DEPTH   = 16;
    localparam int AW      = 4;
    localparam int DW      = 8;
    localparam int IRQ_LVL = 8;

    logic          rx_clk = 1'b0;
    logic          reset_n, rx_done, rd_pop, flush, ovf_clr;
    logic [DW-1:0] rx_data;
    logic          rd_valid, overflow;
    logic [DW-1:0] rd_data;
    logic [AW:0]   count;
`ifdef UART_RX_IRQ_EN
    logic          rx_irq;
`endif

    uart_rx_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (AW),
        .DATA_W (DW)
`ifdef UART_RX_IRQ_EN
        ,
        .IRQ_LEVEL (IRQ_LVL)
`endif
    ) dut (
        .rx_clk   (rx_clk),
        .reset_n  (reset_n),
        .rx_data  (rx_data),
        .rx_done  (rx_done),
        .rd_pop   (rd_pop),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .flush    (flush),
        .ovf_clr  (ovf_clr),
        .overflow (overflow),
`ifdef UART_RX_IRQ_EN
        .rx_irq   (rx_irq),
`endif
        .count    (count)
    );

    always #5 rx_clk = ~rx_clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] q [$];
    logic       m_ovf;
    logic       m_done_prev;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_count"}, 32'(count), 32'(q.size()));
        chk({tag, "_valid"}, 32'(rd_valid), 32'(q.size() != 0));
        chk({tag, "_ovf"}, 32'(overflow), 32'(m_ovf));
        if (q.size() != 0) chk({tag, "_data"}, 32'(rd_data), 32'(q[0]));
`ifdef UART_RX_IRQ_EN
        chk({tag, "_irq"}, 32'(rx_irq), 32'((q.size() >= IRQ_LVL) || m_ovf));
`endif
    endtask

    // One clock: called at a negedge, drives inputs, advances the model, checks at next negedge.
    task automatic step(input logic done, input logic [7:0] d, input logic pop,
                        input logic fl, input logic oc);
        logic push, popv, set;
        rx_done = done; rx_data = d; rd_pop = pop; flush = fl; ovf_clr = oc;
        push = done & ~m_done_prev;
        popv = pop & (q.size() != 0);
        set  = 1'b0;
        if (fl) begin
            q.delete();
        end else begin
            if (popv) void'(q.pop_front());
            if (push) begin
                if (q.size() < DEPTH) q.push_back(d);
                else set = 1'b1;
            end
        end
        m_ovf = set ? 1'b1 : (oc ? 1'b0 : m_ovf);
        m_done_prev = done;
        @(posedge rx_clk);
        @(negedge rx_clk);
        check_state("step");
    endtask

    task automatic push_byte(input logic [7:0] b);
        step(1'b1, b, 1'b0, 1'b0, 1'b0);
        step(1'b0, b, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pop_byte();
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    endtask

    logic [7:0] t2_bytes [4];

    initial begin
        reset_n = 1'b0; rx_done = 1'b0; rx_data = 8'h00; rd_pop = 1'b0;
        flush = 1'b0; ovf_clr = 1'b0;
        m_ovf = 1'b0; m_done_prev = 1'b1;
        t2_bytes[0] = 8'h55; t2_bytes[1] = 8'hA3; t2_bytes[2] = 8'h00; t2_bytes[3] = 8'hFF;
        @(negedge rx_clk);
        @(negedge rx_clk);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_valid", 32'(rd_valid), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_data", 32'(rd_data), 32'd0);
        reset_n = 1'b1;

        // Idle after reset.
        for (int i = 0; i < 100; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // Four loopback bytes, then drain in order.
        for (int i = 0; i < 4; i++) push_byte(t2_bytes[i]);
        chk("t2_count", 32'(count), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("t2_pop", 32'(rd_data), 32'(t2_bytes[i]));
            pop_byte();
        end
        chk("t2_empty", 32'(rd_valid), 32'd0);

        // Overfill by one byte.
        for (int i = 0; i < 17; i++) push_byte(8'(i));
        chk("t3_count", 32'(count), 32'd16);
        chk("t3_ovf", 32'(overflow), 32'd1);
        for (int i = 0; i < 16; i++) begin
            chk("t3_pop", 32'(rd_data), 32'(i));
            pop_byte();
        end
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("t3_ovfclr", 32'(overflow), 32'd0);

        // Full FIFO with simultaneous pop and push.
        for (int i = 0; i < 16; i++) push_byte(8'h10 + 8'(i));
        step(1'b1, 8'h7E, 1'b1, 1'b0, 1'b0);
        chk("t4_count", 32'(count), 32'd16);
        chk("t4_ovf", 32'(overflow), 32'd0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) pop_byte();
        chk("t4_last", 32'(rd_data), 32'h7E);
        pop_byte();

        // Held strobe yields one push; reset mid-frame.
        for (int i = 0; i < 5; i++) step(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);
        chk("t5_count", 32'(count), 32'd1);
        chk("t5_data", 32'(rd_data), 32'h3C);
        step(1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b0;
        #1;
        chk("t5_rst_count", 32'(count), 32'd0);
        chk("t5_rst_valid", 32'(rd_valid), 32'd0);
        q.delete(); m_ovf = 1'b0; m_done_prev = 1'b1;
        @(negedge rx_clk);
        reset_n = 1'b1;
        step(1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
        chk("t5_no_push", 32'(count), 32'd0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        push_byte(8'hC5);
        chk("t5_next", 32'(rd_data), 32'hC5);
        pop_byte();

        // Threshold interrupt, then flush against a same-cycle push.
        for (int i = 0; i < 7; i++) push_byte(8'hA0 + 8'(i));
`ifdef UART_RX_IRQ_EN
        chk("t6_irq7", 32'(rx_irq), 32'd0);
`endif
        push_byte(8'hA7);
`ifdef UART_RX_IRQ_EN
        chk("t6_irq8", 32'(rx_irq), 32'd1);
`endif
        pop_byte();
`ifdef UART_RX_IRQ_EN
        chk("t6_irqpop", 32'(rx_irq), 32'd0);
`endif
        step(1'b1, 8'hAB, 1'b1, 1'b1, 1'b0);
        chk("t6_flush_count", 32'(count), 32'd0);
        chk("t6_flush_valid", 32'(rd_valid), 32'd0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // Random traffic: fill-biased phase then drain-biased phase.
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom),
                 1'($urandom_range(0, 99) < ((i < 300) ? 20 : 65)),
                 1'($urandom_range(0, 99) < 2),
                 1'($urandom_range(0, 99) < 5));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side buffer directly downstream of rx_core.
- Captures each byte rx_core produces on a rising edge of rx_done.
- Stores bytes in a synchronous show-ahead FIFO.
- Presents bytes to the Avalon slave register logic through a valid/pop read port.
- Reports fill level, a sticky overflow flag and, optionally, a threshold interrupt.

Parameters:
DEPTH, 16, number of byte entries; power of two, minimum 2
ADDR_W, 4, pointer width; must equal log2(DEPTH)
DATA_W, 8, byte width; matches rx_core rx_data

Ports:
rx_clk  input  1  single clock, same clock as rx_core
reset_n  input  1  asynchronous active-low reset
rx_data  input  DATA_W  byte from rx_core; sampled in the push cycle
rx_done  input  1  rx_core completion strobe; a rising edge requests a push
rd_pop  input  1  consume the head entry; ignored when rd_valid=0
rd_valid  output  1  FIFO not empty
rd_data  output  DATA_W  head entry (show-ahead)
flush  input  1  synchronous clear of FIFO contents
ovf_clr  input  1  clears the overflow flag
overflow  output  1  sticky: a byte was dropped because the FIFO was full
count  output  ADDR_W+1  current occupancy, 0..DEPTH

Behaviour:
Reset (asynchronous, reset_n=0):
- wr_ptr, rd_ptr, count and overflow are 0.
- rd_valid is 0; rd_data is 0 (reads as don't-care while empty).
- The internal rx_done_d register is 1, so an rx_done already high at reset release causes no push.
- Memory contents are not reset.

Edge detect:
- push_req = rx_done & ~rx_done_d, evaluated combinationally.
- rx_done_d <= rx_done every cycle.
- A level held high across several cycles yields exactly one push.

Push:
- On push_req with space available: mem[wr_ptr] <= rx_data; wr_ptr increments and wraps modulo DEPTH.
- Latency: the byte is visible on rd_valid/rd_data in the cycle after the push cycle.

Pop:
- On rd_pop & rd_valid: rd_ptr increments and wraps.
- rd_data shows the next entry in the following cycle.

count update:
- push only: +1. Pop only: -1. Both together: unchanged.

Full (count == DEPTH):
- push_req alone: byte dropped, overflow <= 1, contents unchanged.
- push_req with a valid pop in the same cycle: push accepted, no overflow.

Empty:
- rd_pop is ignored.
- A same-cycle push is accepted and there is no bypass; rd_valid rises the next cycle.

overflow:
- Set takes priority over a same-cycle ovf_clr.
- Otherwise ovf_clr clears it.

flush:
- Pointers and count go to 0 next cycle.
- flush beats any same-cycle push or pop; that byte is lost and not counted as overflow.
- overflow is unaffected.

Other rules:
- rd_valid = (count != 0), registered consistently with count.
- Reset mid-frame clears all state immediately; only rx_core edges after reset release are captured.

Optional Feature:
Macro UART_RX_IRQ_EN.

Defined:
- Adds parameter IRQ_LEVEL (default DEPTH/2).
- Adds output rx_irq (1 bit, reset 0), registered: rx_irq <= (next count >= IRQ_LEVEL) | next overflow.
- rx_irq therefore asserts the same cycle rd_valid reflects the triggering push.

Undefined:
- rx_irq port and logic are absent.
- All other behaviour is identical.

Decomposition:
- Shared include uart_defs: UART_DATA_W=8 and the default FIFO depth constant. rx_core, tx_core and this block all use them.
- One natural sub-module: uart_sync_fifo. It contains generic DEPTH/DATA_W storage, pointers, count and the full/empty logic.
- This block wraps uart_sync_fifo with the edge detect, overflow and IRQ logic.
- The tx path reuses uart_sync_fifo ahead of tx_core.

Test Plan:
1. Reset then idle, no rx_done edges -> rd_valid=0, count=0, overflow=0 for 100 cycles.
2. rx_core loopback from tx_core: send 0x55, 0xA3, 0x00, 0xFF with no pops -> count=4; popping yields 0x55, 0xA3, 0x00, 0xFF in order, then rd_valid=0.
3. DEPTH=16: push 17 bytes 0..16 without popping -> count=16, overflow=1; pops return 0..15. ovf_clr -> overflow=0.
4. Full FIFO: rd_pop in the same cycle as an rx_done rising edge carrying 0x7E -> count stays 16, overflow stays 0; the last entry read out is 0x7E.
5. Hold rx_done high 5 cycles with rx_data=0x3C -> exactly one push, count=1. Assert reset_n=0 during an rx_core frame -> count=0 immediately, and the next frame's byte is captured correctly.
6. UART_RX_IRQ_EN, IRQ_LEVEL=8: push 7 bytes -> rx_irq=0; 8th -> rx_irq=1; pop one -> rx_irq=0. flush -> count=0 next cycle; a same-cycle push is discarded.
